moore_led_checker: RTL and testbench
====================================

# moore_led_checker

Receive-side checker for the Moore LED sequencer. It samples the 8-bit LED pattern the sequencer drives from its pattern ROM and decodes it back to a state index. It tracks the expected 0→1→…→6→0 walk, declares lock after a run of correct transitions, and flags sequence violations. It sits beside the sequencer as a self-check / observability block.

## Interface
- LED_W, 8, LED pattern width
- N_STATES, 7, sequence length; legal indices are 0..N_STATES-1
- LOCK_CNT, 3, consecutive correct transitions required to lock (≥1)
- ERR_W, 8, error counter width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_led  in  LED_W  LED pattern from the sequencer
- i_valid  in  1  sample strobe; i_led is evaluated only when high
- o_index  out  4  last decoded index
- o_index_valid  out  1  last sampled pattern was legal
- o_locked  out  1  sequence locked
- o_seq_err  out  1  one-cycle pulse on a violation while locked
- o_err_count  out  ERR_W  saturating error count (see Configuration)

## Operation
- Legal patterns: index 0 = 8'h00; index k (1..6) = 1<<(k-1). Any other value is illegal.
- Decoded sample classes, relative to the stored previous index prev:
  - good: idx == (prev+1) mod N_STATES
  - hold: idx == prev
  - jump: any other legal idx
  - illegal: pattern not legal
- FSM states are IDLE, ACQUIRE and LOCKED. The run counter is ceil(log2(LOCK_CNT+1)) bits.
- IDLE:
  - legal → ACQUIRE, prev=idx, run=0
  - illegal → stay
- ACQUIRE:
  - good → prev=idx, run+1; when run+1==LOCK_CNT → LOCKED
  - hold → no change
  - jump → prev=idx, run=0
  - illegal → IDLE, run=0
- LOCKED:
  - good or hold → stay, prev updated on good
  - jump → o_seq_err, ACQUIRE, prev=idx, run=0
  - illegal → o_seq_err, IDLE
- Wrap: 6→0 (8'h20→8'h00) counts as good.
- i_valid low: all state and outputs hold, and o_seq_err is 0.
- On an illegal sample: o_index_valid=0 and o_index holds its old value. On a legal sample: o_index=idx and o_index_valid=1.
- o_locked is high exactly while the state is LOCKED.

## Timing
- Reset values: o_index=0, o_index_valid=0, o_locked=0, o_seq_err=0, o_err_count=0. State=IDLE, prev=0, run=0.
- Reset is asynchronous and takes effect immediately, including mid-sequence while LOCKED. The first sample after deassertion is treated as a fresh IDLE sample.
- Latency: all outputs are registered and reflect the sample taken at edge N starting from edge N (visible in cycle N+1).
- o_locked rises on the same edge that accepts the LOCK_CNT-th good sample.
- o_seq_err is high for exactly one cycle per violating sample. Back-to-back violating samples on consecutive i_valid cycles cannot both pulse, because the first one already exits LOCKED.

## Configuration
- Macro: MOORE_LED_CHECK_STATS_EN.
- Defined: o_err_count increments by 1 on each o_seq_err pulse and on each illegal sample in ACQUIRE. Illegal samples in IDLE do not count. The counter saturates at all-ones and never wraps.
- Undefined: the counter logic is removed and o_err_count is tied to 0. Port list is unchanged.

## Structure
- Package moore_led_pkg holds:
  - N_STATES and the LED pattern constants per index (shared with the sequencer ROM)
  - state enum IDLE/ACQUIRE/LOCKED
- Sub-module led_onehot_decode is purely combinational. It maps i_led to {legal, idx}.
- The FSM, run counter, prev register and stats counter live in moore_led_checker.

## Test plan
- Lock: samples 00,01,02,04 with i_valid each cycle → o_locked=1 after the 4th sample; o_index=3; o_seq_err never high.
- Wrap and hold: while locked, feed 08,10,20,20,00,01 → stays locked; o_index ends at 1; no o_seq_err.
- Jump: while locked at index 4 (8'h08), feed 8'h20 → o_seq_err one cycle, o_locked=0, o_index=6, err_count+1. Then 00,01,02 → relock.
- Illegal: while locked, feed 8'h03 → o_seq_err pulse, o_index_valid=0, o_index unchanged, state IDLE. A further 8'h03 in IDLE → no count change.
- Saturation: with MOORE_LED_CHECK_STATS_EN and ERR_W=2, cause 5 counted errors → o_err_count=3. Without the macro → o_err_count stays 0.
- Reset mid-operation: pull i_rst_n low while locked, between clock edges → all outputs 0 before the next edge. After release, 02,04,08,10 → lock after the 4th sample.

Source files
------------

// File: rtl/moore_led_pkg.sv
// Shared constants for the Moore LED sequencer and its checker.
// LED pattern per state index and the checker FSM state type.
package moore_led_pkg;

  localparam int N_STATES = 7;

  localparam logic [7:0] LED_PAT0 = 8'h00;
  localparam logic [7:0] LED_PAT1 = 8'h01;
  localparam logic [7:0] LED_PAT2 = 8'h02;
  localparam logic [7:0] LED_PAT3 = 8'h04;
  localparam logic [7:0] LED_PAT4 = 8'h08;
  localparam logic [7:0] LED_PAT5 = 8'h10;
  localparam logic [7:0] LED_PAT6 = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } chk_state_e;

  // LED pattern driven for a given state index
  function automatic logic [7:0] led_pattern(input logic [3:0] idx);
    logic [7:0] p;
    p = 8'hFF;
    unique case (idx)
      4'd0: p = LED_PAT0;
      4'd1: p = LED_PAT1;
      4'd2: p = LED_PAT2;
      4'd3: p = LED_PAT3;
      4'd4: p = LED_PAT4;
      4'd5: p = LED_PAT5;
      4'd6: p = LED_PAT6;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_onehot_decode.sv
// Maps an LED pattern back to its state index.
// Purely combinational; legal is low for any unknown pattern.
module led_onehot_decode
  import moore_led_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic [LED_W-1:0] led_i,
  output logic             legal_o,
  output logic [3:0]       idx_o
);

  // Compare against every legal pattern
  always_comb begin
    legal_o = 1'b0;
    idx_o   = 4'd0;
    for (int k = 0; k < N_STATES; k++) begin
      if (led_i == LED_W'(led_pattern(4'(k)))) begin
        legal_o = 1'b1;
        idx_o   = 4'(k);
      end
    end
  end

endmodule

// File: rtl/moore_led_checker.sv
// Receive-side sequence checker for the Moore LED sequencer.
// MOORE_LED_CHECK_STATS_EN enables the saturating error counter.
module moore_led_checker
  import moore_led_pkg::*;
#(
  parameter int LED_W    = 8,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [LED_W-1:0] i_led,
  input  logic             i_valid,
  output logic [3:0]       o_index,
  output logic             o_index_valid,
  output logic             o_locked,
  output logic             o_seq_err,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  chk_state_e       state_q;
  logic [3:0]       prev_q;
  logic [RUN_W-1:0] run_q;
  logic [3:0]       index_q;
  logic             index_valid_q;
  logic             seq_err_q;

  logic       legal;
  logic [3:0] idx;
  logic [3:0] nxt;
  logic       good;
  logic       hold;

  led_onehot_decode #(
    .LED_W(LED_W)
  ) u_dec (
    .led_i  (i_led),
    .legal_o(legal),
    .idx_o  (idx)
  );

  // Classify the sample relative to the stored index
  always_comb begin
    nxt  = (prev_q == 4'(N_STATES - 1)) ? 4'd0 : prev_q + 4'd1;
    good = legal && (idx == nxt);
    hold = legal && (idx == prev_q);
  end

  // Checker FSM with run counter and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      prev_q        <= 4'd0;
      run_q         <= '0;
      index_q       <= 4'd0;
      index_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      seq_err_q <= 1'b0;
      if (i_valid) begin
        index_valid_q <= legal;
        if (legal) index_q <= idx;
        unique case (state_q)
          IDLE: begin
            if (legal) begin
              state_q <= ACQUIRE;
              prev_q  <= idx;
              run_q   <= '0;
            end
          end
          ACQUIRE: begin
            if (!legal) begin
              state_q <= IDLE;
              run_q   <= '0;
            end else if (good) begin
              prev_q <= idx;
              run_q  <= run_q + 1'b1;
              if (run_q + 1'b1 == RUN_W'(LOCK_CNT))
                state_q <= LOCKED;
            end else if (!hold) begin
              prev_q <= idx;
              run_q  <= '0;
            end
          end
          LOCKED: begin
            if (!legal) begin
              seq_err_q <= 1'b1;
              state_q   <= IDLE;
              run_q     <= '0;
            end else if (good) begin
              prev_q <= idx;
            end else if (!hold) begin
              seq_err_q <= 1'b1;
              state_q   <= ACQUIRE;
              prev_q    <= idx;
              run_q     <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_index       = index_q;
  assign o_index_valid = index_valid_q;
  assign o_locked      = (state_q == LOCKED);
  assign o_seq_err     = seq_err_q;

`ifdef MOORE_LED_CHECK_STATS_EN
  logic [ERR_W-1:0] err_q;
  logic             err_ev;

  // Errors: violations while locked, illegal samples while acquiring
  always_comb begin
    err_ev = 1'b0;
    if (i_valid) begin
      if (state_q == ACQUIRE && !legal) err_ev = 1'b1;
      if (state_q == LOCKED && !good && !hold) err_ev = 1'b1;
    end
  end

  // Saturating error counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= '0;
    end else if (err_ev && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign o_err_count = err_q;
`else
  assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_moore_led_checker.sv
// Directed-vector bench for moore_led_checker.
// Error counter expectations follow MOORE_LED_CHECK_STATS_EN.
module tb_moore_led_checker;

  localparam int ERR_W = 2;
`ifdef MOORE_LED_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [7:0]       led;
  logic             valid;
  logic [3:0]       index;
  logic             index_valid;
  logic             locked;
  logic             seq_err;
  logic [ERR_W-1:0] err_count;

  int n_vec;
  int n_err;
  int exp_err;

  moore_led_checker #(
    .LED_W   (8),
    .LOCK_CNT(3),
    .ERR_W   (ERR_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_led        (led),
    .i_valid      (valid),
    .o_index      (index),
    .o_index_valid(index_valid),
    .o_locked     (locked),
    .o_seq_err    (seq_err),
    .o_err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic err_hit();
    if (STATS && exp_err < 3) exp_err++;
  endtask

  // Apply one valid sample, then check all outputs after the edge
  task automatic smp(input string tag, input logic [7:0] p,
                     input int ei, input int eiv,
                     input int el, input int es);
    @(negedge clk);
    led   = p;
    valid = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".idx"}, int'(index), ei);
    chk({tag, ".iv"}, int'(index_valid), eiv);
    chk({tag, ".lock"}, int'(locked), el);
    chk({tag, ".serr"}, int'(seq_err), es);
    chk({tag, ".cnt"}, int'(err_count), exp_err);
  endtask

  task automatic gap(input string tag, input int ei, input int el);
    @(negedge clk);
    valid = 1'b0;
    led   = 8'hFF;
    @(posedge clk);
    #1;
    chk({tag, ".idx"}, int'(index), ei);
    chk({tag, ".lock"}, int'(locked), el);
    chk({tag, ".serr"}, int'(seq_err), 0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    exp_err = 0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    led     = 8'h00;
    #2;
    chk("rst.idx", int'(index), 0);
    chk("rst.iv", int'(index_valid), 0);
    chk("rst.lock", int'(locked), 0);
    chk("rst.serr", int'(seq_err), 0);
    chk("rst.cnt", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // lock after 4th sample
    smp("l0", 8'h00, 0, 1, 0, 0);
    smp("l1", 8'h01, 1, 1, 0, 0);
    smp("l2", 8'h02, 2, 1, 0, 0);
    smp("l3", 8'h04, 3, 1, 1, 0);
    gap("g0", 3, 1);
    gap("g1", 3, 1);

    // wrap and hold while locked
    smp("w4", 8'h08, 4, 1, 1, 0);
    smp("w5", 8'h10, 5, 1, 1, 0);
    smp("w6", 8'h20, 6, 1, 1, 0);
    smp("wh", 8'h20, 6, 1, 1, 0);
    smp("w0", 8'h00, 0, 1, 1, 0);
    smp("w1", 8'h01, 1, 1, 1, 0);

    // jump from 4 to 6
    smp("j2", 8'h02, 2, 1, 1, 0);
    smp("j3", 8'h04, 3, 1, 1, 0);
    smp("j4", 8'h08, 4, 1, 1, 0);
    err_hit();
    smp("jj", 8'h20, 6, 1, 0, 1);
    gap("jg", 6, 0);
    smp("r0", 8'h00, 0, 1, 0, 0);
    smp("r1", 8'h01, 1, 1, 0, 0);
    smp("r2", 8'h02, 2, 1, 1, 0);

    // illegal while locked, then illegal in IDLE
    err_hit();
    smp("il", 8'h03, 2, 0, 0, 1);
    smp("ii", 8'h03, 2, 0, 0, 0);

    // illegal in ACQUIRE counts, drives counter to saturation
    smp("a0", 8'h00, 0, 1, 0, 0);
    err_hit();
    smp("ai", 8'h03, 0, 0, 0, 0);
    smp("b0", 8'h00, 0, 1, 0, 0);
    err_hit();
    smp("bi", 8'h81, 0, 0, 0, 0);
    smp("c0", 8'h00, 0, 1, 0, 0);
    err_hit();
    smp("ci", 8'hFF, 0, 0, 0, 0);

    // jump in ACQUIRE restarts the run
    smp("d0", 8'h00, 0, 1, 0, 0);
    smp("d1", 8'h01, 1, 1, 0, 0);
    smp("dj", 8'h08, 4, 1, 0, 0);
    smp("d5", 8'h10, 5, 1, 0, 0);
    smp("d6", 8'h20, 6, 1, 0, 0);
    smp("d7", 8'h00, 0, 1, 1, 0);

    // asynchronous reset while locked
    @(negedge clk);
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.idx", int'(index), 0);
    chk("ar.iv", int'(index_valid), 0);
    chk("ar.lock", int'(locked), 0);
    chk("ar.serr", int'(seq_err), 0);
    chk("ar.cnt", int'(err_count), 0);
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // fresh acquire with a hold in between
    smp("p2", 8'h02, 2, 1, 0, 0);
    smp("ph", 8'h02, 2, 1, 0, 0);
    smp("p3", 8'h04, 3, 1, 0, 0);
    smp("p4", 8'h08, 4, 1, 0, 0);
    smp("p5", 8'h10, 5, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
